// File: rtl/wb_frame_fetch.sv
// wb_frame_fetch: Wishbone classic-read master that streams a contiguous block of
// 32-bit words from BlockRAM into a small prefetch FIFO. The FIFO is presented
// downstream as a valid/ready stream.
// Optional build macro: WB_FRAME_FETCH_LOOP_EN. When defined, the block restarts
// the block fetch at BASE_WORD after every WORD_COUNT words, for continuous frame
// refresh. When it is undefined, one start yields exactly one run.
module wb_frame_fetch #(
    parameter int ADR_WIDTH  = 11,
    parameter int BASE_WORD  = 0,
    parameter int WORD_COUNT = 2048,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] dat_ms,
    input  logic [31:0] dat_sm,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = ADR_WIDTH + 1;

    localparam logic [CW-1:0]        FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [ADR_WIDTH-1:0] BASE_PTR   = ADR_WIDTH'(BASE_WORD);
    localparam logic [RW-1:0]        RUN_WORDS  = RW'(WORD_COUNT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]           state;
    logic [ADR_WIDTH-1:0] word_ptr;
    logic [RW-1:0]        remaining;
    logic                 done_q;
    logic                 error_q;

    logic [31:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;

    logic                 fetching;
    logic                 bus_ack;
    logic                 bus_err;
    logic                 push;
    logic                 pop;
    logic                 last_word;

    // Bus handshake decode. An err outranks ack, rty counts as no ack, and any
    // response arriving while stb is low is ignored.
    always_comb begin
        fetching   = (state == FETCH);
        bus_err    = fetching && err;
        bus_ack    = fetching && ack && !rty && !err;
        push       = bus_ack;
        pop        = out_valid && out_ready;
        last_word  = (remaining == RW'(1));
        count_next = count + CW'(push) - CW'(pop);
    end

    // Fetch controller: walks the word pointer, throttles on a full FIFO and
    // waits for the stream to drain before reporting completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_ptr  <= BASE_PTR;
            remaining <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_ptr  <= BASE_PTR;
                        remaining <= RUN_WORDS;
                        error_q   <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus_err) begin
                        error_q <= 1'b1;
                        state   <= IDLE;
                    end else if (bus_ack) begin
                        word_ptr <= word_ptr + 1'b1;
                        if (last_word) begin
`ifdef WB_FRAME_FETCH_LOOP_EN
                            word_ptr  <= BASE_PTR;
                            remaining <= RUN_WORDS;
                            done_q    <= 1'b1;
                            state     <= (count_next == FULL_CNT) ? HOLD : FETCH;
`else
                            remaining <= remaining - 1'b1;
                            state     <= DRAIN;
`endif
                        end else begin
                            remaining <= remaining - 1'b1;
                            state     <= (count_next == FULL_CNT) ? HOLD : FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (count < FULL_CNT) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (count_next == '0) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping. A bus error discards everything already prefetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus_err) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // FIFO storage is plain memory with no reset. The head word is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= dat_sm;
        end
    end

    // Output mapping. cyc/stb come straight from the state register, so reset drops them at once.
    always_comb begin
        cyc       = fetching;
        stb       = fetching;
        we        = 1'b0;
        sel       = 4'hF;
        cti       = 3'b000;
        bte       = 2'b00;
        dat_ms    = 32'd0;
        adr       = fetching ? (32'(word_ptr) << 2) : 32'd0;
        busy      = (state != IDLE);
        done      = done_q;
        error     = error_q;
        out_valid = (count != '0);
        out_data  = out_valid ? fifo_mem[rd_ptr] : 32'd0;
    end

`ifndef SYNTHESIS
    // The controller must never overfill or underflow the FIFO.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && count == FULL_CNT));
            assert (!(pop && count == '0));
        end
    end
`endif

endmodule
